uart_ctrl: RTL and testbench
============================

// Module: uart_ctrl
// PURPOSE
//  Device-side responder for the bridge's UART strobe interface (CPU MMIO 0xbfd003f8 data, 0xbfd003fc status).
//  Serialises bytes written by the LSU onto txd_o and deserialises rxd_i into a one-byte holding register.
//  Drives the tx_ready/rx_ready status bits the bridge returns on a status read.
//  Frame format: 8N1, LSB first.
// PARAMETERS
//  CLK_FREQ  50_000_000  core clock in Hz
//  BAUD      9600        line rate; localparam DIV = CLK_FREQ/BAUD clocks per bit, DIV >= 4 (elaboration error otherwise)
// PORTS
//  clk                input   1  core clock, all logic on posedge
//  rst_n              input   1  asynchronous active-low reset
//  uart_we_n_i        input   1  write strobe from bridge, low-active, may stay low several cycles
//  uart_re_n_i        input   1  read strobe from bridge, low-active, may stay low several cycles
//  uart_tx_data_i     input   8  byte to transmit, valid while uart_we_n_i low
//  uart_tx_ready_o    output  1  1 = transmitter idle, next write accepted
//  uart_rx_ready_o    output  1  1 = unread byte in uart_rx_data_o
//  uart_rx_data_o     output  8  last received byte
//  uart_rx_overrun_o  output  1  sticky: a byte arrived while rx_ready was 1; cleared by accepted read
//  uart_rx_ferr_o     output  1  sticky: stop bit sampled 0; cleared by accepted read
//  txd_o              output  1  serial out, idle high
//  rxd_i              input   1  serial in, asynchronous to clk
// BEHAVIOUR
//  Reset: txd_o=1, tx_ready=1, rx_ready=0, rx_data=0, overrun=0, ferr=0, both FSMs idle, strobe history regs=1.
//  Reset mid-frame aborts immediately; txd_o returns high asynchronously, partial RX byte discarded.
//  Strobe accept: edge-detected. Write accepted only in the cycle where we_n=0 and we_n_q=1 (prev cycle).
//   Likewise for reads. Held-low strobes never cause a second accept.
//  Write accepted while tx_ready=1: latch uart_tx_data_i, tx_ready=0 next cycle.
//   Write accepted while tx_ready=0: byte dropped, no state change.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   START drives 0 for DIV clocks, beginning the cycle after accept.
//   DATA drives bit[0..7], DIV clocks each; a 3-bit index selects the bit.
//   STOP drives 1 for DIV clocks.
//   tx_ready=1 in the cycle after the last STOP clock. Accept to tx_ready high = 10*DIV+1 cycles.
//  RX input: rxd_i passes through a 2-flop synchroniser, reset value 1. The FSM sees rxd_s.
//  RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: rxd_s==0 -> START, counter cleared.
//   START: after DIV/2 clocks sample rxd_s. If 1, treat as glitch and go to IDLE. If 0, go to DATA.
//   DATA: sample every DIV clocks (bit centre), shift into bit 7 (LSB first); after 8 samples go to STOP.
//   STOP: after DIV clocks sample rxd_s.
//    If 1: load rx_data, rx_ready=1 next cycle; set overrun if rx_ready was already 1.
//    If 0: set ferr; rx_data and rx_ready unchanged.
//    Either way return to IDLE; a new start is detected from the next cycle.
//  Read accepted: rx_ready, overrun and ferr cleared next cycle; rx_data held.
//  Simultaneous read accept and good-stop load in the same cycle: the load wins.
//   rx_ready stays 1, rx_data = new byte, overrun not set, ferr cleared.
//  Bit counters: ceil(log2(DIV)) bits, reload to 0 on terminal count DIV-1; no free-running wrap.
//  TX and RX run independently; full duplex.
//  Outputs are registered except where stated; no combinational path from strobes to outputs.
// TESTING  (CLK_FREQ=16, BAUD=1 -> DIV=16)
//  T1 rst_n low 3 cycles, release -> txd_o=1, tx_ready=1, rx_ready=0, rx_data=0x00, flags 0.
//  T2 we_n low 1 cycle, data 0x55 -> from next cycle txd_o = 0,1,0,1,0,1,0,1,0,1, 16 clocks each.
//     tx_ready low for exactly 161 cycles after accept.
//  T3 we_n held low 40 cycles with 0xA3, then a second write 0x11 mid-frame -> exactly one frame of 0xA3 sent.
//  T4 drive 8N1 frame 0xC6 on rxd_i at DIV=16 -> rx_ready=1, rx_data=0xC6.
//     Then a read strobe -> rx_ready=0, rx_data still 0xC6.
//  T5 two frames 0x12, 0x34 without a read -> rx_data=0x34, overrun=1.
//     A frame 0x56 with stop bit 0 -> ferr=1, rx_data stays 0x34.
//     A read clears overrun and ferr.
//  T6 rxd_i low 4 clocks then high -> no byte, FSM idle.
//     Assert rst_n mid-TX frame -> txd_o=1 immediately, tx_ready=1 after release.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: strobe-driven 8N1 UART responder with a one-byte RX holding register.
// State | meaning (shared by TX and RX FSMs)
//   S_IDLE  | line idle, waiting for a write (TX) or a falling edge on rxd_s (RX)
//   S_START | start bit: TX drives 0, RX waits half a bit to confirm it
//   S_DATA  | eight data bits, LSB first, one per DIV clocks
//   S_STOP  | stop bit: TX drives 1, RX samples and loads or flags a framing error
module uart_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_we_n_i,
    input  logic       uart_re_n_i,
    input  logic [7:0] uart_tx_data_i,
    output logic       uart_tx_ready_o,
    output logic       uart_rx_ready_o,
    output logic [7:0] uart_rx_data_o,
    output logic       uart_rx_overrun_o,
    output logic       uart_rx_ferr_o,
    output logic       txd_o,
    input  logic       rxd_i
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_TC   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_ctrl: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic          r_we_n_q, r_re_n_q;
    logic          w_we_acc, w_re_acc;

    logic [1:0]    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_idx;
    logic [7:0]    r_tx_data;
    logic          r_txd, r_tx_ready;
    logic          w_tx_tc;

    logic          r_rx_s1, r_rx_s2;
    logic          w_rxd_s;
    logic [1:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_idx;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_ready, r_rx_ovr, r_rx_ferr;
    logic          w_rx_tc, w_rx_half, w_rx_good, w_rx_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_n_q <= 1'b1;
            r_re_n_q <= 1'b1;
        end else begin
            r_we_n_q <= uart_we_n_i;
            r_re_n_q <= uart_re_n_i;
        end
    end

    assign w_we_acc = !uart_we_n_i && r_we_n_q;
    assign w_re_acc = !uart_re_n_i && r_re_n_q;

    assign w_tx_tc = (r_tx_cnt == CNT_TC);

    // tx_ready rises one cycle after returning to idle, giving 10*DIV+1 busy cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            if (r_tx_state == S_IDLE || w_tx_tc) r_tx_cnt <= '0;
            else                                 r_tx_cnt <= r_tx_cnt + 1'b1;
            case (r_tx_state)
                S_IDLE: begin
                    if (w_we_acc && r_tx_ready) begin
                        r_tx_data  <= uart_tx_data_i;
                        r_txd      <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_state <= S_START;
                    end else if (!r_tx_ready) begin
                        r_tx_ready <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tx_tc) begin
                        r_tx_idx   <= 3'd0;
                        r_txd      <= r_tx_data[0];
                        r_tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tx_tc) begin
                        if (r_tx_idx == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx_idx <= r_tx_idx + 3'd1;
                            r_txd    <= r_tx_data[r_tx_idx + 3'd1];
                        end
                    end
                end
                default: begin
                    if (w_tx_tc) r_tx_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd_i;
            r_rx_s2 <= r_rx_s1;
        end
    end

    assign w_rxd_s   = r_rx_s2;
    assign w_rx_tc   = (r_rx_cnt == CNT_TC);
    assign w_rx_half = (r_rx_state == S_START) && (r_rx_cnt == CNT_HALF);
    assign w_rx_good = (r_rx_state == S_STOP) && w_rx_tc && w_rxd_s;
    assign w_rx_bad  = (r_rx_state == S_STOP) && w_rx_tc && !w_rxd_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else begin
            if (r_rx_state == S_IDLE || w_rx_tc || w_rx_half) r_rx_cnt <= '0;
            else                                             r_rx_cnt <= r_rx_cnt + 1'b1;
            case (r_rx_state)
                S_IDLE: begin
                    if (!w_rxd_s) r_rx_state <= S_START;
                end
                S_START: begin
                    if (w_rx_half) begin
                        r_rx_idx   <= 3'd0;
                        r_rx_state <= w_rxd_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_rx_tc) begin
                        r_rx_shift <= {w_rxd_s, r_rx_shift[7:1]};
                        r_rx_idx   <= r_rx_idx + 3'd1;
                        if (r_rx_idx == 3'd7) r_rx_state <= S_STOP;
                    end
                end
                default: begin
                    if (w_rx_tc) r_rx_state <= S_IDLE;
                end
            endcase
        end
    end

    // A good-stop load in the same cycle as a read overrides the read's clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_ready <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if (w_re_acc) begin
                r_rx_ready <= 1'b0;
                r_rx_ovr   <= 1'b0;
                r_rx_ferr  <= 1'b0;
            end
            if (w_rx_good) begin
                r_rx_data  <= r_rx_shift;
                r_rx_ready <= 1'b1;
                if (r_rx_ready && !w_re_acc) r_rx_ovr <= 1'b1;
            end
            if (w_rx_bad) r_rx_ferr <= 1'b1;
        end
    end

    assign uart_tx_ready_o   = r_tx_ready;
    assign txd_o             = r_txd;
    assign uart_rx_ready_o   = r_rx_ready;
    assign uart_rx_data_o    = r_rx_data;
    assign uart_rx_overrun_o = r_rx_ovr;
    assign uart_rx_ferr_o    = r_rx_ferr;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: scoreboard bench for uart_ctrl at DIV=16 (CLK_FREQ=16, BAUD=1).
module tb_uart_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       we_n, re_n, rxd;
    logic [7:0] tx_data;
    logic       tx_ready, rx_ready, rx_ovr, rx_ferr, txd;
    logic [7:0] rx_data;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_ctrl #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_we_n_i       (we_n),
        .uart_re_n_i       (re_n),
        .uart_tx_data_i    (tx_data),
        .uart_tx_ready_o   (tx_ready),
        .uart_rx_ready_o   (rx_ready),
        .uart_rx_data_o    (rx_data),
        .uart_rx_overrun_o (rx_ovr),
        .uart_rx_ferr_o    (rx_ferr),
        .txd_o             (txd),
        .rxd_i             (rxd)
    );

    // Called right after the negedge on which the write strobe was driven low.
    task automatic tx_monitor(output int errs, output int low);
        logic [7:0] b;
        logic       e;
        int         bi;
        errs = 0;
        low  = 0;
        b    = tx_q.pop_front();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            bi = (k / 16) - 1;
            if (k < 16)       e = 1'b0;
            else if (k < 144) e = b[bi[2:0]];
            else              e = 1'b1;
            if (txd !== e) errs++;
            if (tx_ready === 1'b1) break;
            low++;
        end
    endtask

    // Drives one frame starting at the current time (just after a negedge).
    task automatic rx_send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic read_pulse;
        re_n = 1'b0;
        @(negedge clk);
        re_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; we_n = 1'b1; re_n = 1'b1; rxd = 1'b1; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else n_pass++;
        n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); else n_pass++;
        n_total++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); else n_pass++;
        n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
        n_total++; if (rx_ovr !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", rx_ovr); else n_pass++;
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", rx_ferr); else n_pass++;
    endtask

    task automatic test_tx_frame;
        int errs, low;
        we_n = 1'b0; tx_data = 8'h55; tx_q.push_back(8'h55);
        fork
            tx_monitor(errs, low);
            begin @(negedge clk); we_n = 1'b1; end
        join
        n_total++; if (errs !== 0) $display("FAIL tx55_bits: got %0d bad samples expected 0", errs); else n_pass++;
        n_total++; if (low !== 161) $display("FAIL tx55_busy: got %0d cycles expected 161", low); else n_pass++;
    endtask

    task automatic test_held_write;
        int errs, low, quiet_bad;
        we_n = 1'b0; tx_data = 8'hA3; tx_q.push_back(8'hA3);
        fork
            tx_monitor(errs, low);
            begin
                repeat (40) @(negedge clk);
                we_n = 1'b1;
                repeat (40) @(negedge clk);
                we_n = 1'b0; tx_data = 8'h11;
                @(negedge clk);
                we_n = 1'b1;
            end
        join
        n_total++; if (errs !== 0) $display("FAIL txA3_bits: got %0d bad samples expected 0", errs); else n_pass++;
        n_total++; if (low !== 161) $display("FAIL txA3_busy: got %0d cycles expected 161", low); else n_pass++;
        quiet_bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_ready !== 1'b1) quiet_bad++;
        end
        n_total++; if (quiet_bad !== 0) $display("FAIL tx_extra_frame: got %0d active cycles expected 0", quiet_bad); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int errs, low;
        we_n = 1'b0; tx_data = 8'h3C; tx_q.push_back(8'h3C);
        fork
            tx_monitor(errs, low);
            begin @(negedge clk); we_n = 1'b1; end
        join
        n_total++; if (errs !== 0) $display("FAIL tx3C_bits: got %0d bad samples expected 0", errs); else n_pass++;
        n_total++; if (low !== 161) $display("FAIL tx3C_busy: got %0d cycles expected 161", low); else n_pass++;
        // second write in the first ready cycle, strobe then left low
        we_n = 1'b0; tx_data = 8'hC3; tx_q.push_back(8'hC3);
        tx_monitor(errs, low);
        n_total++; if (errs !== 0) $display("FAIL txC3_bits: got %0d bad samples expected 0", errs); else n_pass++;
        n_total++; if (low !== 161) $display("FAIL txC3_busy: got %0d cycles expected 161", low); else n_pass++;
        repeat (50) @(negedge clk);
        n_total++; if (tx_ready !== 1'b1) $display("FAIL held_strobe_reaccept: got tx_ready %b expected 1", tx_ready); else n_pass++;
        we_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rx_frame;
        logic [7:0] e;
        rx_q.push_back(8'hC6);
        rx_send(8'hC6, 1'b1);
        e = rx_q.pop_front();
        n_total++; if (rx_ready !== 1'b1) $display("FAIL rxC6_ready: got %b expected 1", rx_ready); else n_pass++;
        n_total++; if (rx_data !== e) $display("FAIL rxC6_data: got %h expected %h", rx_data, e); else n_pass++;
        read_pulse();
        n_total++; if (rx_ready !== 1'b0) $display("FAIL rxC6_read_ready: got %b expected 0", rx_ready); else n_pass++;
        n_total++; if (rx_data !== e) $display("FAIL rxC6_read_data: got %h expected %h", rx_data, e); else n_pass++;
    endtask

    task automatic test_overrun_ferr;
        logic [7:0] e;
        rx_q.push_back(8'h12);
        rx_send(8'h12, 1'b1);
        e = rx_q.pop_front();
        n_total++; if (rx_data !== e) $display("FAIL rx12_data: got %h expected %h", rx_data, e); else n_pass++;
        n_total++; if (rx_ovr !== 1'b0) $display("FAIL rx12_overrun: got %b expected 0", rx_ovr); else n_pass++;
        rx_q.push_back(8'h34);
        rx_send(8'h34, 1'b1);
        e = rx_q.pop_front();
        n_total++; if (rx_data !== e) $display("FAIL rx34_data: got %h expected %h", rx_data, e); else n_pass++;
        n_total++; if (rx_ovr !== 1'b1) $display("FAIL rx34_overrun: got %b expected 1", rx_ovr); else n_pass++;
        rx_send(8'h56, 1'b0);
        repeat (20) @(negedge clk);
        n_total++; if (rx_ferr !== 1'b1) $display("FAIL rx56_ferr: got %b expected 1", rx_ferr); else n_pass++;
        n_total++; if (rx_data !== e) $display("FAIL rx56_data_kept: got %h expected %h", rx_data, e); else n_pass++;
        read_pulse();
        n_total++; if (rx_ovr !== 1'b0) $display("FAIL read_clr_overrun: got %b expected 0", rx_ovr); else n_pass++;
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL read_clr_ferr: got %b expected 0", rx_ferr); else n_pass++;
        n_total++; if (rx_ready !== 1'b0) $display("FAIL read_clr_ready: got %b expected 0", rx_ready); else n_pass++;
    endtask

    // Stop sample lands on posedge 155 of the frame; read strobe low on negedge 154.
    task automatic test_read_load_collision;
        logic [7:0] e;
        rx_q.push_back(8'h21);
        rx_send(8'h21, 1'b1);
        e = rx_q.pop_front();
        n_total++; if (rx_data !== e) $display("FAIL rx21_data: got %h expected %h", rx_data, e); else n_pass++;
        rx_send(8'h00, 1'b0);
        repeat (20) @(negedge clk);
        n_total++; if (rx_ferr !== 1'b1) $display("FAIL rx00_ferr: got %b expected 1", rx_ferr); else n_pass++;
        rx_q.push_back(8'h7E);
        fork
            rx_send(8'h7E, 1'b1);
            begin
                repeat (154) @(negedge clk);
                read_pulse();
            end
        join
        e = rx_q.pop_front();
        n_total++; if (rx_ready !== 1'b1) $display("FAIL coll_ready: got %b expected 1", rx_ready); else n_pass++;
        n_total++; if (rx_data !== e) $display("FAIL coll_data: got %h expected %h", rx_data, e); else n_pass++;
        n_total++; if (rx_ovr !== 1'b0) $display("FAIL coll_overrun: got %b expected 0", rx_ovr); else n_pass++;
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL coll_ferr: got %b expected 0", rx_ferr); else n_pass++;
        read_pulse();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_rx_glitch;
        logic [7:0] e;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        n_total++; if (rx_ready !== 1'b0) $display("FAIL glitch_ready: got %b expected 0", rx_ready); else n_pass++;
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL glitch_ferr: got %b expected 0", rx_ferr); else n_pass++;
        rx_q.push_back(8'h9A);
        rx_send(8'h9A, 1'b1);
        e = rx_q.pop_front();
        n_total++; if (rx_ready !== 1'b1) $display("FAIL rx9A_ready: got %b expected 1", rx_ready); else n_pass++;
        n_total++; if (rx_data !== e) $display("FAIL rx9A_data: got %h expected %h", rx_data, e); else n_pass++;
        read_pulse();
    endtask

    task automatic test_reset_mid_tx;
        we_n = 1'b0; tx_data = 8'hF0;
        @(negedge clk);
        we_n = 1'b1;
        repeat (49) @(negedge clk);
        n_total++; if (txd !== 1'b0) $display("FAIL midtx_txd: got %b expected 0", txd); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL midtx_busy: got %b expected 0", tx_ready); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (txd !== 1'b1) $display("FAIL async_rst_txd: got %b expected 1", txd); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (tx_ready !== 1'b1) $display("FAIL post_rst_tx_ready: got %b expected 1", tx_ready); else n_pass++;
        n_total++; if (txd !== 1'b1) $display("FAIL post_rst_txd: got %b expected 1", txd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_held_write();
        test_back_to_back();
        test_rx_frame();
        test_overrun_ferr();
        test_read_load_collision();
        test_rx_glitch();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end
endmodule
